// File: rtl/lane_memory_bank.sv
// lane_memory_bank: multi-line bit-addressable state memory with registered bit read,
// per-line snapshot commit and a one-line-per-cycle bank clear.
module lane_memory_bank #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 5,
  parameter int IW    = 5,
  parameter int LW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             init,
  input  logic [WIDTH-1:0] line,
  input  logic [LW-1:0]    lsel,
  input  logic [IW-1:0]    index,
  input  logic             val,
  input  logic             write,
  input  logic             read,
  input  logic             firstread,
  input  logic             ok,
  output logic             out,
  output logic             rvalid,
  output logic [WIDTH-1:0] mem,
  output logic             mvalid,
  output logic             busy,
  output logic             err
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t           state_q, state_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] lines_q [DEPTH];
  logic [WIDTH-1:0] lines_d [DEPTH];
  logic             out_q, out_d, rvalid_q, rvalid_d, mvalid_q, mvalid_d, err_q, err_d;
  logic [WIDTH-1:0] mem_q, mem_d;
  logic [IW-1:0]    p;
  logic             lsel_ok, idx_ok, last;
  assign p       = IW'(WIDTH - 1) - index;
  assign lsel_ok = {1'b0, lsel} < (LW + 1)'(DEPTH);
  assign idx_ok  = {1'b0, index} < (IW + 1)'(WIDTH);
  assign last    = cnt_q == LW'(DEPTH - 1);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lines_d  = lines_q;
    out_d    = out_q;
    rvalid_d = 1'b0;
    mem_d    = mem_q;
    mvalid_d = 1'b0;
    err_d    = err_q;
    if (state_q == CLEAR) begin
      lines_d[cnt_q] = '0;
      cnt_d          = last ? '0 : cnt_q + LW'(1);
      state_d        = last ? IDLE : CLEAR;
    end else if (clear) begin
      state_d = CLEAR;
    end else begin
      err_d = err_q | ((init | write | read | ok) & ~lsel_ok) | ((write | read) & ~idx_ok);
      // init is applied after write so it overrides a write to the same line
      if (write && lsel_ok && idx_ok) lines_d[lsel][p] = val;
      if (init && lsel_ok) lines_d[lsel] = line;
      if (read) begin
        rvalid_d = 1'b1;
        out_d    = (lsel_ok && idx_ok) ? (firstread ? line[p] : lines_q[lsel][p]) : 1'b0;
      end
      if (ok && lsel_ok) begin
        mvalid_d = 1'b1;
        mem_d    = lines_q[lsel];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lines_q  <= '{default: '0};
      out_q    <= 1'b0;
      rvalid_q <= 1'b0;
      mem_q    <= '0;
      mvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lines_q  <= lines_d;
      out_q    <= out_d;
      rvalid_q <= rvalid_d;
      mem_q    <= mem_d;
      mvalid_q <= mvalid_d;
      err_q    <= err_d;
    end
  end
  assign out    = out_q;
  assign rvalid = rvalid_q;
  assign mem    = mem_q;
  assign mvalid = mvalid_q;
  assign busy   = state_q == CLEAR;
  assign err    = err_q;
endmodule

// File: doc/lane_memory_bank.md
# lane_memory_bank

Multi-line, bit-addressable state memory for the permutation datapath: holds DEPTH lines of WIDTH bits, supports whole-line load, single-bit read/write with MSB-first indexing, a registered bit read port and a per-line snapshot commit. Parametrised successor of the single-line 25-bit state block. Adds line selection, registered read with valid, range checking and a multi-cycle bank clear. Sits between the line loader and the per-bit compute engine.

## Interface
- WIDTH, 25, bits per line
- DEPTH, 5, number of lines
- IW, 5, bit-index width (≥ clog2(WIDTH))
- LW, 3, line-select width (≥ clog2(DEPTH))
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  start bank clear (ignored while busy)
- init  in  1  load `line` into line `lsel`
- line  in  WIDTH  load data; also source for firstread
- lsel  in  LW  line select for init/write/read/ok
- index  in  IW  bit index, 0 = MSB (physical bit WIDTH-1-index)
- val  in  1  write data
- write  in  1  write `val` to bit `index` of line `lsel`
- read  in  1  read bit `index` of line `lsel`
- firstread  in  1  with read: take bit from `line` input instead of memory
- ok  in  1  commit: snapshot line `lsel` to `mem`
- out  out  1  registered read data, holds between reads
- rvalid  out  1  one-cycle pulse, `out` updated
- mem  out  WIDTH  last committed snapshot, holds between commits
- mvalid  out  1  one-cycle pulse, `mem` updated
- busy  out  1  clear in progress
- err  out  1  sticky: out-of-range index or lsel seen on an accepted op

## Operation
- Physical bit p = WIDTH-1-index (WIDTH=25: index 0 → bit 24, index 24 → bit 0).
- FSM: IDLE, CLEAR. IDLE→CLEAR on clear; counter c=0..DEPTH-1 zeroes line c per cycle; CLEAR→IDLE after line DEPTH-1. busy=1 exactly in CLEAR (DEPTH cycles).
- During CLEAR all init/write/read/ok ignored (no rvalid, no mvalid, no err update).
- init: mem[lsel] ← line. write: mem[lsel][p] ← val.
- init and write same line same cycle: init wins, write dropped. Different lines: both take effect.
- read: out ← firstread ? line[p] : mem[lsel][p]; rvalid=1 next cycle. firstread without read has no effect.
- read and write same bit same cycle: read returns old value.
- ok: mem ← mem[lsel] (pre-update value of that cycle); mvalid=1 next cycle.
- Range: index ≥ WIDTH on write/read, or lsel ≥ DEPTH on any op → op suppressed (read still pulses rvalid with out=0), err set; err clears only on rst. index range ignored for init/ok.
- clear and other op same cycle in IDLE: clear taken, other ops dropped.

## Timing
- Reset (rst=1 at edge): all lines 0, out=0, rvalid=0, mem=0, mvalid=0, busy=0, err=0, FSM IDLE, counter 0. Reset mid-CLEAR aborts clear; lines already untouched stay cleared to 0 by reset anyway.
- Read latency 1 cycle; commit latency 1 cycle; write/init visible to a read issued the next cycle.
- Back-to-back reads every cycle supported; rvalid high each cycle.
- clear: busy rises the cycle after clear is sampled, falls DEPTH cycles later; first op accepted on the cycle busy is low.

## Test plan
- Reset, then init lsel=2 line=25'h1555555, read lsel=2 index=0 → out=1 (bit 24), index=1 → out=0, rvalid one cycle each.
- write lsel=0 index=24 val=1 then ok lsel=0 → mem=25'h0000001, mvalid pulse; out holds prior value.
- Same cycle write index=3 val=1 and read index=3 on a zero line → out=0; next-cycle read → out=1.
- firstread=1 read with line=25'h1000000 index=0, memory zero → out=1; memory unchanged on later normal read → 0.
- read index=25 or lsel=5 → rvalid=1, out=0, err=1 and stays 1; write index=30 leaves all lines unchanged.
- Fill all 5 lines with 25'h1FFFFFF, pulse clear with a simultaneous write → busy high 5 cycles, ops during busy ignored, afterwards every line commits as 0; rst asserted in cycle 2 of clear → busy=0 next cycle.
